// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl -- pipeline hazard / stall controller
//
// Purpose:
//   Decides each cycle whether the front of the pipeline advances, holds or
//   is flushed. Three event sources are arbitrated with a fixed priority:
//     1. branch_taken  : flush IF/ID, let the PC take the branch target,
//                        abort any multi-cycle hold in progress.
//     2. multi-cycle op: hold IF/ID and PC for exactly mc_len cycles
//                        (SAD / find-min competition instructions).
//     3. load-use      : hold IF/ID and PC for a single cycle while a load
//                        in ID/EX produces a register the IF/ID op reads.
//
// Handshake / timing:
//   There is no valid/ready pairing here. stall, pc_write, ifid_write and
//   ifid_flush are combinational from the current state and the current
//   inputs and are meant to be consumed by the pipeline registers on the
//   same rising edge. busy and stall_cycles are registered-state outputs.
//
// Ports:
//   clk            in   1  clock, all state updates on the rising edge
//   rst_n          in   1  synchronous active-low reset
//   idex_memread   in   1  ID/EX instruction is a load
//   idex_rt        in   5  destination register of that load
//   ifid_rs        in   5  rs source of the IF/ID instruction
//   ifid_rt        in   5  rt source of the IF/ID instruction
//   ifid_uses_rt   in   1  IF/ID instruction actually reads rt
//   mc_req         in   1  IF/ID instruction is a multi-cycle op
//   mc_len         in   4  number of stall cycles that op needs (0..15)
//   branch_taken   in   1  branch resolved taken in EX
//   stall          out  1  zeroes ID/EX control signals
//   pc_write       out  1  PC update enable
//   ifid_write     out  1  IF/ID load enable
//   ifid_flush     out  1  turns IF/ID into a NOP
//   busy           out  1  controller is inside a multi-cycle hold
//   stall_cycles   out 16  saturating count of cycles with stall=1
//
// Configuration:
//   STALL_CTRL_PERF_CNT_EN  when defined, stall_cycles is a live saturating
//                           counter; when undefined it is tied to zero and
//                           no counter register exists.
// -----------------------------------------------------------------------------
module stall_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        mc_req,
    input  logic [3:0]  mc_len,
    input  logic        branch_taken,
    output logic        stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        busy,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MC_STALL = 2'b01,
        ST_RELEASE  = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic lu_hz;
    logic stall_c, pc_write_c, ifid_write_c, ifid_flush_c;

    // Load-use hazard. Register 0 is hard-wired to zero, so a load into it
    // never creates a dependency.
    always_comb begin
        lu_hz = idex_memread && (idex_rt != 5'd0) &&
                ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    end

    // -------------------------------------------------------------------------
    // Next-state and raw output decode.
    // cnt holds the number of MC_STALL cycles still to come, including the
    // current one; the IDLE cycle that accepts the op is the first stall
    // cycle, so it loads mc_len-1.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_c      = 1'b0;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        ifid_flush_c = 1'b0;

        if (branch_taken) begin
            // The wrong-path instruction in IF/ID is squashed and the PC is
            // redirected, so both registers must still load.
            stall_c      = 1'b1;
            ifid_flush_c = 1'b1;
            state_d      = ST_IDLE;
            cnt_d        = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mc_req && (mc_len != 4'd0)) begin
                        stall_c      = 1'b1;
                        pc_write_c   = 1'b0;
                        ifid_write_c = 1'b0;
                        cnt_d        = mc_len - 4'd1;
                        state_d      = (mc_len >= 4'd2) ? ST_MC_STALL : ST_RELEASE;
                    end else if (lu_hz) begin
                        stall_c      = 1'b1;
                        pc_write_c   = 1'b0;
                        ifid_write_c = 1'b0;
                    end
                end

                ST_MC_STALL: begin
                    stall_c      = 1'b1;
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    if (cnt_q <= 4'd1) begin
                        // Last hold cycle; cnt_q==0 cannot occur normally
                        // but is treated the same so the FSM cannot stick.
                        cnt_d   = 4'd0;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end

                ST_RELEASE: begin
                    // The multi-cycle instruction is still sitting in IF/ID
                    // with mc_req high; ignoring mc_req here lets it move on
                    // instead of re-triggering itself.
                    if (lu_hz) begin
                        stall_c      = 1'b1;
                        pc_write_c   = 1'b0;
                        ifid_write_c = 1'b0;
                    end
                    state_d = ST_IDLE;
                end

                default: begin
                    // Unused encoding: behave as a plain pipeline cycle and
                    // recover to IDLE on the next edge.
                    if (lu_hz) begin
                        stall_c      = 1'b1;
                        pc_write_c   = 1'b0;
                        ifid_write_c = 1'b0;
                    end
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output stage: while reset is asserted the pipeline runs freely.
    // -------------------------------------------------------------------------
    always_comb begin
        stall      = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        busy       = 1'b0;
        if (rst_n) begin
            stall      = stall_c;
            pc_write   = pc_write_c;
            ifid_write = ifid_write_c;
            ifid_flush = ifid_flush_c;
            busy       = (state_q == ST_MC_STALL);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stall-cycle performance counter.
    // -------------------------------------------------------------------------
`ifdef STALL_CTRL_PERF_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    // stall is already forced low during reset, so no extra rst_n term.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl -- scoreboard bench for stall_ctrl
//
// The driver applies one cycle of inputs shortly after each rising edge,
// predicts the outputs for that cycle from a behavioural model and pushes
// them into exp_q. The monitor pops one entry on every falling edge and
// compares it with the DUT outputs.
//
// Model: "owed" is the number of further hold cycles the multi-cycle
// instruction in IF/ID still needs; "in_release" marks the one cycle after a
// hold ends, where the held instruction must not re-trigger itself.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        ifid_uses_rt;
  logic        mc_req;
  logic [3:0]  mc_len;
  logic        branch_taken;
  logic        stall;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        busy;
  logic [15:0] stall_cycles;

  // {stall, pc_write, ifid_write, ifid_flush, busy, stall_cycles}
  logic [20:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  int owed = 0;
  bit in_release = 1'b0;
  int stall_count = 0;

  stall_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .mc_req       (mc_req),
    .mc_len       (mc_len),
    .branch_taken (branch_taken),
    .stall        (stall),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver + reference model ----------------
  task automatic drive(input bit r, input bit mr, input logic [4:0] lrt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input bit ur, input bit mq, input logic [3:0] ml,
                       input bit br);
    bit e_st, e_pc, e_iw, e_fl, e_busy, lu;
    logic [15:0] e_cnt;
    @(posedge clk);
    #1;
    rst_n        = r;
    idex_memread = mr;
    idex_rt      = lrt;
    ifid_rs      = rs;
    ifid_rt      = rt;
    ifid_uses_rt = ur;
    mc_req       = mq;
    mc_len       = ml;
    branch_taken = br;

    lu = mr && (lrt != 0) && ((lrt == rs) || (ur && (lrt == rt)));
    e_st = 0; e_pc = 1; e_iw = 1; e_fl = 0; e_busy = 0;
`ifdef STALL_CTRL_PERF_CNT_EN
    e_cnt = 16'(stall_count);
`else
    e_cnt = 16'd0;
`endif

    if (!r) begin
      owed = 0;
      in_release = 0;
      stall_count = 0;
    end else begin
      e_busy = (owed > 0);
      if (br) begin
        e_st = 1; e_fl = 1;
        owed = 0;
        in_release = 0;
      end else if (owed > 0) begin
        e_st = 1; e_pc = 0; e_iw = 0;
        owed = owed - 1;
        in_release = (owed == 0);
      end else if (!in_release && mq && ml != 0) begin
        e_st = 1; e_pc = 0; e_iw = 0;
        owed = int'(ml) - 1;
        in_release = (ml == 1);
      end else if (lu) begin
        e_st = 1; e_pc = 0; e_iw = 0;
        in_release = 0;
      end else begin
        in_release = 0;
      end
      if (e_st && stall_count < 65535) stall_count++;
    end
    exp_q.push_back({e_st, e_pc, e_iw, e_fl, e_busy, e_cnt});
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mc(input logic [3:0] ml, input bit br);
    drive(1, 0, 0, 0, 0, 0, 1, ml, br);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [20:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {stall, pc_write, ifid_write, ifid_flush, busy, stall_cycles};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t stall/pcw/ifw/flush/busy act=%b%b%b%b%b exp=%b%b%b%b%b stall_cycles act=%0d exp=%0d",
                 $time, a[20], a[19], a[18], a[17], a[16],
                 e[20], e[19], e[18], e[17], e[16], a[15:0], e[15:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_uses_rt = 0; mc_req = 0; mc_len = 0; branch_taken = 0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // load-use on rs, then on rt, then rt not used
    drive(1, 1, 8, 8, 3, 0, 0, 0, 0);
    idle();
    drive(1, 1, 9, 2, 9, 1, 0, 0, 0);
    drive(1, 1, 9, 2, 9, 0, 0, 0, 0);
    // $zero never hazards
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
    idle();

    // mc_len=4 held through the hold and the release cycle
    repeat (5) mc(4, 0);
    idle();
    idle();

    // mc_len=0 acts as a normal instruction, mc_len=1 is a single stall
    mc(0, 0);
    mc(1, 0);
    mc(1, 0);
    idle();

    // branch abort with two hold cycles left
    repeat (3) mc(5, 0);
    mc(5, 1);
    idle();

    // reset on the 2nd cycle of an mc_len=5 op
    mc(5, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 5, 0);
    idle();
    idle();

    // counter: 3 load-use stalls plus one mc_len=4 op
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 8, 8, 0, 0, 0, 0, 0);
    idle();
    drive(1, 1, 8, 8, 0, 0, 0, 0, 0);
    idle();
    drive(1, 1, 7, 1, 7, 1, 0, 0, 0);
    idle();
    repeat (4) mc(4, 0);
    idle();
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 59) != 0),
            $urandom_range(0, 1),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 1),
            ($urandom_range(0, 4) == 0),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 11) == 0));
    end
    idle();

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset; synchronous and active-low; sampled only on the rising edge of clk.
REQ-003 SHALL have port idex_memread  in  1  the instruction in ID/EX is a load.
REQ-004 SHALL have port idex_rt  in  5  destination register of the ID/EX load.
REQ-005 SHALL have port ifid_rs  in  5  source register rs of the instruction in IF/ID.
REQ-006 SHALL have port ifid_rt  in  5  source register rt of the instruction in IF/ID.
REQ-007 SHALL have port ifid_uses_rt  in  1  the IF/ID instruction reads rt.
REQ-008 SHALL have port mc_req  in  1  the IF/ID instruction is a multi-cycle competition op (SAD/find-min).
REQ-009 SHALL have port mc_len  in  4  number of stall cycles that op requires (0..15).
REQ-010 SHALL have port branch_taken  in  1  branch resolved taken in EX.
REQ-011 SHALL have port stall  out  1  drives the stall input of the ID/EX control-zeroing mux.
REQ-012 SHALL have port pc_write  out  1  PC update enable.
REQ-013 SHALL have port ifid_write  out  1  IF/ID register load enable.
REQ-014 SHALL have port ifid_flush  out  1  clears IF/ID to a NOP.
REQ-015 SHALL have port busy  out  1  FSM is in MC_STALL.
REQ-016 SHALL have port stall_cycles  out  16  count of cycles with stall=1.

Function
REQ-017 SHALL define lu_hz = idex_memread & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)); the check is combinational.
REQ-018 SHALL implement FSM states IDLE, MC_STALL, RELEASE, encoded in 2 bits; the unused encoding SHALL return to IDLE on the next edge.
REQ-019 SHALL apply priority branch_taken > multi-cycle > load-use in every state.
REQ-020 SHALL, whenever branch_taken=1: stall=1, ifid_flush=1, pc_write=1, ifid_write=1; next state IDLE; counter cleared; this applies in any state, including an abort of MC_STALL.
REQ-021 SHALL, in IDLE with mc_req=1 and mc_len>=1: stall=1, pc_write=0, ifid_write=0 that cycle; load cnt=mc_len-1; go to MC_STALL if mc_len>=2, else RELEASE.
REQ-022 SHALL treat mc_req with mc_len=0 as a normal instruction.
REQ-023 SHALL, in MC_STALL: stall=1, pc_write=0, ifid_write=0, busy=1; cnt decrements; on the cycle cnt==1, go to RELEASE; mc_req is ignored.
REQ-024 SHALL, in RELEASE: ignore mc_req (no retrigger by the held instruction); evaluate lu_hz normally; go to IDLE next cycle.
REQ-025 SHALL, on lu_hz=1 with no higher-priority event: stall=1, pc_write=0, ifid_write=0 for that cycle only; the FSM state is unchanged.
REQ-026 SHALL, with no event: stall=0, pc_write=1, ifid_write=1, ifid_flush=0.
REQ-027 SHALL make the total stall cycles for a multi-cycle op exactly mc_len; the first stall cycle is the cycle mc_req is seen in IDLE.
REQ-028 SHALL make all outputs except stall_cycles and busy combinational from state and inputs; busy SHALL be decoded from state only.

Reset
REQ-029 SHALL, on rst_n=0 at a clock edge: state=IDLE, cnt=0, stall_cycles=0; this applies mid-MC_STALL as well.
REQ-030 SHALL force stall=0, pc_write=1, ifid_write=1, ifid_flush=0, busy=0 on outputs while rst_n=0.

Configuration
REQ-031 SHALL gate the performance counter with macro STALL_CTRL_PERF_CNT_EN.
REQ-032 SHALL, when STALL_CTRL_PERF_CNT_EN is defined: increment stall_cycles on every edge where stall=1 and rst_n=1, saturating at 16'hFFFF.
REQ-033 SHALL, when STALL_CTRL_PERF_CNT_EN is not defined: tie stall_cycles to 0 and synthesize no counter register.

Verification
REQ-034 SHALL cover load-use: idex_memread=1, idex_rt=8, ifid_rs=8 for 1 cycle -> stall=1, pc_write=0, ifid_write=0 for exactly 1 cycle; state stays IDLE.
REQ-035 SHALL cover the $zero case: idex_memread=1, idex_rt=0, ifid_rs=0 -> stall=0.
REQ-036 SHALL cover a multi-cycle op: mc_req=1, mc_len=4 held -> stall=1 for exactly 4 cycles, busy=1 for 3 of them, then RELEASE with stall=0, then IDLE.
REQ-037 SHALL cover branch abort: during MC_STALL with cnt=2, branch_taken=1 -> ifid_flush=1, stall=1, pc_write=1 that cycle; next state IDLE.
REQ-038 SHALL cover reset mid-op: rst_n=0 on the 2nd cycle of an mc_len=5 stall -> next cycle state IDLE, busy=0, stall_cycles=0.
REQ-039 SHALL cover the counter: with STALL_CTRL_PERF_CNT_EN defined, 3 load-use stalls plus one mc_len=4 op -> stall_cycles=7; without the macro -> stall_cycles=0.
